// File: rtl/karatsuba_combine_serial_if.sv
// Operand/result handshake bundle for the Karatsuba recombination stage.
// The master side presents z0/z1/z2 and accepts the product. The slave side
// is the recombination stage itself.
interface karatsuba_combine_serial_if #(
    parameter int N = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     z0;
    logic [N+1:0]     z1;
    logic [N-1:0]     z2;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, z0, z1, z2, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, z0, z1, z2, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/karatsuba_combine_serial.sv
// Nibble-serial Karatsuba recombination: product = {z2,z0} + ((z1-z2-z0) << M).
// One 4-bit carry-select slice per adder, used once per cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SUB   | forming mid = z1 + ~z2 + ~z0 + 2, one nibble per cycle, LSB first
// ADD   | adding mid into accumulator nibbles M/4 and up, one per cycle
// DONE  | product held with out_valid=1 until out_ready
module karatsuba_combine_serial #(
    parameter int N = 16,
    parameter int M = N / 2
) (
    input  logic clk,
    input  logic rst,
    karatsuba_combine_serial_if.slave io
);
    localparam int W   = N + 2;               // mid width
    localparam int S   = (W + 3) / 4;         // SUB nibble cycles
    localparam int A   = (2 * N - M) / 4;     // ADD nibble cycles
    localparam int MW  = S * 4;               // nibble-padded operand width for SUB
    localparam int DN  = (A > S) ? A : S;     // mid nibbles readable during ADD
    localparam int DW  = DN * 4;
    localparam int AW  = 2 * N;
    localparam int CW  = $clog2(DN + 1);

    // Bits of the padded mid that belong to the N+2-bit result; the rest stay zero.
    localparam logic [MW-1:0] MID_MASK = MW'({W{1'b1}});

    typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   z1_q, z1_d;
    logic [MW-1:0]   z2n_q, z2n_d;
    logic [MW-1:0]   z0n_q, z0n_d;
    logic [DW-1:0]   mid_q, mid_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   nib_q, nib_d;
    logic            c1_q, c1_d;
    logic            c2_q, c2_d;
    logic            ca_q, ca_d;
    logic [AW-1:0]   product_q, product_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    // 4-bit carry-select group: ripple sum, +1 binary-to-excess-1 copy, carry-in picks.
    function automatic logic [4:0] csel_add(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
        logic [4:0] rca;
        logic [4:0] bec;
        rca = {1'b0, a} + {1'b0, b};
        bec = rca + 5'd1;
        return cin ? bec : rca;
    endfunction

    logic [W-1:0] z0_inv;
    logic [W-1:0] z2_inv;
    logic [4:0]   s1;
    logic [4:0]   s2;
    logic [4:0]   sa;
    int           sub_base;
    int           add_base;

    // Next-state and datapath for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        z1_d        = z1_q;
        z2n_d       = z2n_q;
        z0n_d       = z0n_q;
        mid_d       = mid_q;
        acc_d       = acc_q;
        nib_d       = nib_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        ca_d        = ca_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        z0_inv      = '0;
        z2_inv      = '0;
        s1          = '0;
        s2          = '0;
        sa          = '0;
        sub_base    = int'(nib_q) * 4;
        add_base    = (M / 4 + int'(nib_q)) * 4;

        case (state_q)
            IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    // z0/z2 are zero-extended to N+2 bits before inversion.
                    z0_inv      = ~{2'b00, io.z0};
                    z2_inv      = ~{2'b00, io.z2};
                    z1_d        = MW'(io.z1);
                    z0n_d       = MW'(z0_inv);
                    z2n_d       = MW'(z2_inv);
                    acc_d       = {io.z2, io.z0};
                    mid_d       = '0;
                    nib_d       = '0;
                    c1_d        = 1'b1;
                    c2_d        = 1'b1;
                    ca_d        = 1'b0;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SUB;
                end
            end

            SUB: begin
                // The two +1s of the two's-complement negations ride in as initial carries.
                s1 = csel_add(z1_q[sub_base +: 4], z2n_q[sub_base +: 4], c1_q);
                s2 = csel_add(s1[3:0], z0n_q[sub_base +: 4], c2_q);
                c1_d = s1[4];
                c2_d = s2[4];
                mid_d[sub_base +: 4] = s2[3:0] & MID_MASK[sub_base +: 4];
                if (nib_q == CW'(S - 1)) begin
                    nib_d   = '0;
                    ca_d    = 1'b0;
                    state_d = ADD;
                end else begin
                    nib_d = nib_q + CW'(1);
                end
            end

            ADD: begin
                sa = csel_add(acc_q[add_base +: 4], mid_q[sub_base +: 4], ca_q);
                acc_d[add_base +: 4] = sa[3:0];
                ca_d = sa[4];
                if (nib_q == CW'(A - 1)) begin
                    nib_d       = '0;
                    product_d   = acc_d;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    nib_d = nib_q + CW'(1);
                end
            end

            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            z1_q        <= '0;
            z2n_q       <= '0;
            z0n_q       <= '0;
            mid_q       <= '0;
            acc_q       <= '0;
            nib_q       <= '0;
            c1_q        <= 1'b0;
            c2_q        <= 1'b0;
            ca_q        <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            z1_q        <= z1_d;
            z2n_q       <= z2n_d;
            z0n_q       <= z0n_d;
            mid_q       <= mid_d;
            acc_q       <= acc_d;
            nib_q       <= nib_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            ca_q        <= ca_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.product   = product_q;
    assign io.busy      = busy_q;
endmodule
